// File: rtl/hazard_stall_unit.sv
// Front-end hold/flush/bubble control for load-use, taken-branch and EX-busy hazards.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned REG_AW            = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              id_branch_taken,
  input  logic              ex_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_hold,
  output logic              idex_bubble,
  output logic [31:0]       stall_cycles
);

  typedef enum logic {RUN, LSTALL} state_t;

  localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [2:0] REM_INIT    = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic       lu;

  // Register 0 is hard-wired zero, so it can never carry a load-use dependency.
  assign lu = idex_mem_read && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; an EX-busy cycle freezes the stall sequence
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!ex_busy) begin
      case (state_q)
        RUN: begin
          if (lu && MULTI_STALL) begin
            state_d = LSTALL;
            rem_d   = REM_INIT;
          end
        end
        LSTALL: begin
          rem_d = rem_q - 3'd1;
          if (rem_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Mealy outputs, forced low while reset is asserted
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      if (ex_busy) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
      end else if (state_q == LSTALL || lu) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_branch_taken) begin
        ifid_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Saturating count of PC-hold cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (pc_hold && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Produces the pipeline hold, flush and bubble controls for the front end of the SAD pipelined datapath.
- Drives the `PCWrite` hold input of the program counter, where 1 means hold.
- Detects three hazard types:
  - load-use data hazards, with a configurable stall length;
  - taken-branch fetch flushes;
  - multi-cycle execute-unit busy stalls.
- Sits between the ID and EX stage registers; its outputs feed the PC, IF/ID and ID/EX registers.

Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubble cycles inserted per load-use hazard. Legal range 1..7; use 1 with EX forwarding, 2 without.
- `REG_AW`, default 5: register-specifier width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `idex_mem_read`  in  1  instruction in EX is a load
- `idex_rt`  in  `REG_AW`  load destination register in EX
- `ifid_rs`  in  `REG_AW`  rs of instruction in ID
- `ifid_rt`  in  `REG_AW`  rt of instruction in ID
- `ifid_uses_rt`  in  1  ID instruction reads rt as a source
- `id_branch_taken`  in  1  branch resolved taken in ID this cycle
- `ex_busy`  in  1  multi-cycle EX unit (SAD accumulate) not done
- `pc_hold`  out  1  1 = PC keeps its value (drives the PC's `PCWrite`)
- `ifid_hold`  out  1  1 = IF/ID register keeps its value
- `ifid_flush`  out  1  1 = IF/ID loads NOP
- `idex_hold`  out  1  1 = ID/EX register keeps its value
- `idex_bubble`  out  1  1 = ID/EX loads NOP (control bits zero)
- `stall_cycles`  out  32  performance counter (see Optional Feature)

Behaviour:
- Load-use hazard: `lu = idex_mem_read & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)))`.
- FSM states:
  - RUN: reset state.
  - LSTALL: extra load stall cycles.
  - Internal 3-bit counter `rem`, reset 0.
- All outputs are combinational from state, `rem` and inputs (Mealy), so the PC and stage registers see them in the same cycle. No registered latency.
- Priority in any state, highest first:
  1. `ex_busy`
  2. LSTALL
  3. `lu`
  4. `id_branch_taken`
- `ex_busy` = 1:
  - `pc_hold` = `ifid_hold` = `idex_hold` = 1; `ifid_flush` = `idex_bubble` = 0.
  - State and `rem` are frozen.
- RUN, `lu` = 1:
  - `pc_hold` = `ifid_hold` = `idex_bubble` = 1.
  - If `LOAD_STALL_CYCLES` > 1: next state LSTALL, `rem` ← `LOAD_STALL_CYCLES` − 1.
  - Otherwise stay in RUN.
  - `id_branch_taken` is ignored this cycle; the branch re-resolves after the stall.
- RUN, `lu` = 0, `id_branch_taken` = 1: `ifid_flush` = 1; PC not held; all other outputs 0.
- RUN, no event: all control outputs 0.
- LSTALL:
  - `pc_hold` = `ifid_hold` = `idex_bubble` = 1; `rem` ← `rem` − 1.
  - When `rem` == 1, next state is RUN.
  - `lu` and `id_branch_taken` are ignored.
- `ifid_hold` and `ifid_flush` are never both 1. `idex_hold` and `idex_bubble` are never both 1.
- Reset (any time, including mid-LSTALL):
  - State → RUN, `rem` → 0, `stall_cycles` → 0.
  - While reset is asserted, all control outputs read 0, inputs are ignored, and any pending stall is abandoned.
- Register 0 never triggers a hazard.

Optional Feature:
- Macro `HAZARD_PERF_CNT_EN`.
- Defined:
  - `stall_cycles` increments by 1 on each `clk` edge where `pc_hold` = 1.
  - Saturates at `32'hFFFFFFFF`; cleared only by `rst`.
- Undefined: `stall_cycles` is constant 0 and no counter flops are built.

Test Plan:
- Load-use, `LOAD_STALL_CYCLES` = 1:
  - Stimulus: `idex_mem_read` = 1, `idex_rt` = 8, `ifid_rs` = 8.
  - Response: exactly one cycle with `pc_hold` = `ifid_hold` = `idex_bubble` = 1; next cycle (EX holds bubble) all 0.
- Load-use, `LOAD_STALL_CYCLES` = 2:
  - Stimulus: same as above, with `idex_mem_read` deasserted after the first cycle.
  - Response: `pc_hold` high for 2 consecutive cycles, then 0.
- `idex_rt` = 0 matching `ifid_rs` = 0 → no stall. `ifid_uses_rt` = 0 with `idex_rt` == `ifid_rt` = 5 → no stall.
- Branch vs load-use:
  - `id_branch_taken` = 1 alone → `ifid_flush` = 1 for 1 cycle, `pc_hold` = 0.
  - `id_branch_taken` = 1 with `lu` = 1 → `ifid_flush` = 0, `pc_hold` = 1.
- `ex_busy` during LSTALL:
  - Stimulus: `ex_busy` high for 3 cycles in the middle of a 2-cycle load stall.
  - Response: `idex_hold` = 1, `idex_bubble` = 0 during busy; after busy the remaining stall cycle completes. Total `pc_hold` cycles = 5; `stall_cycles` = 5 with `HAZARD_PERF_CNT_EN` defined, 0 without.
- Reset mid-LSTALL:
  - Stimulus: assert `rst` asynchronously between clock edges.
  - Response: outputs drop to 0 immediately; after release, RUN with no residual stall; `stall_cycles` = 0.
